eth1_csr_writer: RTL
====================

# eth1_csr_writer

Single-outstanding register-write master sitting directly downstream of the Eth1 configuration sequencer. It accepts one address/data write request at a time, asserts `busy` while the request is in flight, and performs the write on the Ethernet MAC's Avalon-MM CSR port, honouring `avm_waitrequest`. It bounds every transfer with a timeout and reports completed writes and timeouts.

## Interface
- `ADDR_W`, default 8: request register (word) address width.
- `DATA_W`, default 32: write data width.
- `TIMEOUT_CYC`, default 1023: maximum cycles `avm_write` may be held against `avm_waitrequest`.
- `CNT_W`, default 16: width of the completed-write counter.
- Clocking: one clock; reset is synchronous and active-high.
- `clk_hifreq` in 1: sole clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reg_addr` in ADDR_W: word address of the requested write.
- `data_in` in DATA_W: write data.
- `wren` in 1: request strobe, sampled only while `busy`=0.
- `busy` out 1: request in flight; new requests ignored.
- `avm_address` out ADDR_W+2: byte address, equal to `reg_addr` shifted left by 2.
- `avm_writedata` out DATA_W: captured data.
- `avm_write` out 1: Avalon write strobe.
- `avm_waitrequest` in 1: slave stall.
- `err_clr` in 1: clears `err_timeout`.
- `err_timeout` out 1: sticky timeout flag.
- `wr_count` out CNT_W: number of writes accepted by the slave; wraps.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `busy`=0, `avm_write`=0. If `wren`=1, capture `reg_addr`/`data_in`, clear the timeout counter, go to WRITE.
- WRITE: `busy`=1, `avm_write`=1, address/data held stable.
  - `avm_waitrequest`=0: the transfer completes at this edge; increment `wr_count`; go to DONE.
  - `avm_waitrequest`=1: increment the timeout counter. When the counter equals TIMEOUT_CYC, set `err_timeout`, do not increment `wr_count`, and go to DONE. The write is abandoned.
- DONE: `busy`=1, `avm_write`=0. Unconditionally go to IDLE.
- `wren` while `busy`=1 is ignored, with no queueing. If `wren` is still high on return to IDLE, it is accepted as a new request. The upstream block must drop `wren` once it sees `busy`.
- `err_clr` clears `err_timeout`. If a timeout set and `err_clr` occur in the same cycle, the set wins.
- `wr_count` wraps from 2^CNT_W−1 to 0.
- All outputs are registered.

## Timing
- Reset values:
  - state = IDLE
  - `busy`=0, `avm_write`=0
  - `avm_address`=0, `avm_writedata`=0
  - `err_timeout`=0, `wr_count`=0
  - timeout counter = 0
- Reset mid-transfer: `avm_write` deasserts at the reset edge. The pending write is dropped and not counted.
- Zero-wait write: `wren` high in cycle N produces:
  - `busy` and `avm_write` high in N+1;
  - completion at the end of N+1;
  - DONE in N+2;
  - `busy`=0 in N+3;
  - next request accepted in N+3.
- Each cycle of `avm_waitrequest`=1 extends WRITE by one cycle.
- A timeout occurs after `avm_write` has been high for TIMEOUT_CYC+1 cycles. `err_timeout` rises in the DONE cycle.
- `wr_count` updates in the DONE cycle.

## Structure
- Shared package `eth1_pkg`:
  - `csr_wr_state_t` enum (IDLE, WRITE, DONE);
  - `CSR_BYTE_SHIFT`=2;
  - the default TIMEOUT_CYC constant.
- Sub-module `eth1_timeout_ctr`: clear / enable / terminal-count counter parameterised on its limit. It is reusable by the sequencer's poll loops.
- Everything else (FSM, capture registers, `wr_count`) lives in one module.

## Test plan
- Reset, then `wren`=1 for one cycle with `reg_addr`=0x05, `data_in`=0xDEADBEEF, waitrequest held 0. Required:
  - `avm_write` high for exactly 1 cycle with `avm_address`=0x014 and `avm_writedata`=0xDEADBEEF;
  - `busy` high for 2 cycles;
  - `wr_count`=1.
- Same request with waitrequest=1 for 5 cycles then 0. Required: `avm_write` high for 6 cycles, address/data stable throughout, `wr_count`=1, `err_timeout`=0.
- TIMEOUT_CYC=7, waitrequest stuck at 1. Required:
  - `avm_write` high for 8 cycles, then 0;
  - `err_timeout`=1, `wr_count` unchanged;
  - `busy` low 2 cycles after `avm_write` falls.
  - Then apply `err_clr` together with a second timeout: `err_timeout` stays 1.
- Hold `wren`=1 continuously with zero-wait slave. Required: one write every 3 cycles; changes to `reg_addr`/`data_in` while `busy` do not alter in-flight `avm_address`/`avm_writedata`.
- Assert `rst` while in WRITE with waitrequest=1. Required: next cycle `avm_write`=0, `busy`=0, `wr_count`=0, `err_timeout`=0.
- Preload `wr_count` to 0xFFFF by issuing 65535 zero-wait writes, then one more. Required: `wr_count`=0x0000.

Source files
------------

// File: rtl/eth1_pkg.sv
// Shared Eth1 definitions: CSR writer states and constants.
// Imported by the CSR writer, its interface and the timeout counter.
package eth1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } csr_wr_state_t;

    localparam int CSR_BYTE_SHIFT  = 2;
    localparam int TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/eth1_csr_writer_if.sv
// Avalon-MM CSR write port of the Eth1 MAC.
// Master drives address/data/strobe, slave answers with waitrequest.
interface eth1_csr_writer_if
    import eth1_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W+CSR_BYTE_SHIFT-1:0] avm_address;
    logic [DATA_W-1:0]                avm_writedata;
    logic                             avm_write;
    logic                             avm_waitrequest;

    modport master (
        output avm_address,
        output avm_writedata,
        output avm_write,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_writedata,
        input  avm_write,
        output avm_waitrequest
    );
endinterface

// File: rtl/eth1_timeout_ctr.sv
// Clear/enable counter that saturates at LIMIT and flags terminal count.
// Shared by the CSR writer and the sequencer poll loops.
module eth1_timeout_ctr
    import eth1_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] r_cnt;
    logic         w_tc;

    assign w_tc = (r_cnt == LIM);
    assign tc   = w_tc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && !w_tc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/eth1_csr_writer.sv
// Single-outstanding Avalon-MM CSR write master for the Eth1 MAC.
// Holds one request, bounds the stall with a timeout, counts accepted writes.
module eth1_csr_writer
    import eth1_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 16
) (
    input  logic              clk_hifreq,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wren,
    output logic              busy,
    input  logic              err_clr,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  wr_count,
    eth1_csr_writer_if.master avm
);
    localparam int AW = ADDR_W + CSR_BYTE_SHIFT;

    csr_wr_state_t     r_state;
    logic              r_busy;
    logic              r_write;
    logic              r_err;
    logic [AW-1:0]     r_addr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    logic w_to_clr;
    logic w_to_en;
    logic w_to_tc;

    assign w_to_clr = (r_state == IDLE) && wren;
    assign w_to_en  = (r_state == WRITE) && avm.avm_waitrequest;

    eth1_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_to_ctr (
        .clk (clk_hifreq),
        .rst (rst),
        .clr (w_to_clr),
        .en  (w_to_en),
        .tc  (w_to_tc)
    );

    always_ff @(posedge clk_hifreq) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            // A timeout set below overrides a clear in the same cycle
            if (err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_busy  <= 1'b0;
                    r_write <= 1'b0;
                    if (wren) begin
                        r_addr  <= {reg_addr, {CSR_BYTE_SHIFT{1'b0}}};
                        r_data  <= data_in;
                        r_busy  <= 1'b1;
                        r_write <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (!avm.avm_waitrequest) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_write <= 1'b0;
                        r_state <= DONE;
                    end else if (w_to_tc) begin
                        r_err   <= 1'b1;
                        r_write <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy              = r_busy;
    assign err_timeout       = r_err;
    assign wr_count          = r_cnt;
    assign avm.avm_address   = r_addr;
    assign avm.avm_writedata = r_data;
    assign avm.avm_write     = r_write;
endmodule
